// File: rtl/butterfly_cplx_pipe_pkg.sv
// butterfly_cplx_pipe_pkg: shared defaults, per-sample mode flags and rounding helper
package butterfly_cplx_pipe_pkg;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_TW_WIDTH = 16;
    typedef struct packed {
        logic inverse;
        logic scale;
    } bf_mode_t;
    function automatic int round_const(input int tw_width);
        return 1 << (tw_width - 2);
    endfunction
endpackage

// File: rtl/butterfly_cplx_pipe_mult.sv
// butterfly_cplx_pipe_mult: two-stage complex multiply xb*w (or xb*conj(w)) with round-half-up
module butterfly_cplx_pipe_mult
    import butterfly_cplx_pipe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TW_WIDTH = DEF_TW_WIDTH
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic signed [WIDTH-1:0]    xa_re,
    input  logic signed [WIDTH-1:0]    xa_im,
    input  logic signed [WIDTH-1:0]    xb_re,
    input  logic signed [WIDTH-1:0]    xb_im,
    input  logic signed [TW_WIDTH-1:0] w_re,
    input  logic signed [TW_WIDTH-1:0] w_im,
    input  bf_mode_t                   mode,
    output logic signed [WIDTH+1:0]    t_re,
    output logic signed [WIDTH+1:0]    t_im,
    output logic signed [WIDTH-1:0]    xa_re_q,
    output logic signed [WIDTH-1:0]    xa_im_q,
    output logic                       scale_q
);
    localparam int P = WIDTH + TW_WIDTH;
    localparam int S = P + 1;
    localparam int R = WIDTH + 2;
    localparam logic signed [S-1:0] RND = S'(round_const(TW_WIDTH));
    logic signed [P-1:0] ac, bd, ad, bc;
    logic signed [WIDTH-1:0] xa_re1, xa_im1;
    bf_mode_t mode1;
    logic signed [S-1:0] sum_re, sum_im;
    // S1: four partial products plus the side-band data travelling with the sample
    always_ff @(posedge clk)
        if (en) begin
            ac     <= P'(xb_re) * P'(w_re);
            bd     <= P'(xb_im) * P'(w_im);
            ad     <= P'(xb_re) * P'(w_im);
            bc     <= P'(xb_im) * P'(w_re);
            xa_re1 <= xa_re;
            xa_im1 <= xa_im;
            mode1  <= mode;
        end
    // conjugate by flipping the sign of the sums, so w = -1.0 never needs negating
    always_comb begin
        sum_re = mode1.inverse ? S'(ac) + S'(bd) : S'(ac) - S'(bd);
        sum_im = mode1.inverse ? S'(bc) - S'(ad) : S'(ad) + S'(bc);
    end
    // S2: round back to data scale, two guard bits keep the full product range
    always_ff @(posedge clk)
        if (en) begin
            t_re    <= R'((sum_re + RND) >>> (TW_WIDTH - 1));
            t_im    <= R'((sum_im + RND) >>> (TW_WIDTH - 1));
            xa_re_q <= xa_re1;
            xa_im_q <= xa_im1;
            scale_q <= mode1.scale;
        end
endmodule

// File: rtl/butterfly_cplx_pipe.sv
// butterfly_cplx_pipe: pipelined radix-2 DIT complex butterfly with stall handshake, scaling and saturation
module butterfly_cplx_pipe
    import butterfly_cplx_pipe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TW_WIDTH = DEF_TW_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic signed [WIDTH-1:0]    i_xa_re,
    input  logic signed [WIDTH-1:0]    i_xa_im,
    input  logic signed [WIDTH-1:0]    i_xb_re,
    input  logic signed [WIDTH-1:0]    i_xb_im,
    input  logic signed [TW_WIDTH-1:0] i_w_re,
    input  logic signed [TW_WIDTH-1:0] i_w_im,
    input  logic                       i_inverse,
    input  logic                       i_scale,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [WIDTH-1:0]    o_ya_re,
    output logic signed [WIDTH-1:0]    o_ya_im,
    output logic signed [WIDTH-1:0]    o_yb_re,
    output logic signed [WIDTH-1:0]    o_yb_im,
    output logic                       o_sat
);
    localparam int R = WIDTH + 2;
    localparam logic signed [R-1:0] MAX = R'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [R-1:0] MIN = R'(-(2 ** (WIDTH - 1)));
    logic adv, v1, v2, scale2;
    logic signed [R-1:0] t_re, t_im;
    logic signed [WIDTH-1:0] xa_re2, xa_im2;
    logic [WIDTH:0] ya_re_s, ya_im_s, yb_re_s, yb_im_s;
    // returns {saturated, value}; optional halving rounds half up before clipping
    function automatic logic [WIDTH:0] sat_clip(input logic signed [R-1:0] y, input logic sc);
        logic signed [R-1:0] z;
        z = sc ? (y + R'(1)) >>> 1 : y;
        return (z > MAX) ? {1'b1, MAX[WIDTH-1:0]} : (z < MIN) ? {1'b1, MIN[WIDTH-1:0]} : {1'b0, z[WIDTH-1:0]};
    endfunction
    assign adv     = !o_valid | i_ready;
    assign o_ready = adv;
    butterfly_cplx_pipe_mult #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_mult (
        .clk     (i_clk),
        .en      (adv),
        .xa_re   (i_xa_re),
        .xa_im   (i_xa_im),
        .xb_re   (i_xb_re),
        .xb_im   (i_xb_im),
        .w_re    (i_w_re),
        .w_im    (i_w_im),
        .mode    ('{inverse: i_inverse, scale: i_scale}),
        .t_re    (t_re),
        .t_im    (t_im),
        .xa_re_q (xa_re2),
        .xa_im_q (xa_im2),
        .scale_q (scale2)
    );
    // S3 datapath: add/sub at guarded width, then scale and clip
    always_comb begin
        ya_re_s = sat_clip(R'(xa_re2) + t_re, scale2);
        ya_im_s = sat_clip(R'(xa_im2) + t_im, scale2);
        yb_re_s = sat_clip(R'(xa_re2) - t_re, scale2);
        yb_im_s = sat_clip(R'(xa_im2) - t_im, scale2);
    end
    // valid chain and output registers; outputs keep their last value when no sample arrives
    always_ff @(posedge i_clk)
        if (i_reset) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_valid <= 1'b0;
            o_ya_re <= '0;
            o_ya_im <= '0;
            o_yb_re <= '0;
            o_yb_im <= '0;
            o_sat   <= 1'b0;
        end else if (adv) begin
            v1      <= i_valid;
            v2      <= v1;
            o_valid <= v2;
            if (v2) begin
                o_ya_re <= ya_re_s[WIDTH-1:0];
                o_ya_im <= ya_im_s[WIDTH-1:0];
                o_yb_re <= yb_re_s[WIDTH-1:0];
                o_yb_im <= yb_im_s[WIDTH-1:0];
                o_sat   <= ya_re_s[WIDTH] | ya_im_s[WIDTH] | yb_re_s[WIDTH] | yb_im_s[WIDTH];
            end
        end
endmodule

// File: tb/tb_butterfly_cplx_pipe.sv
// tb_butterfly_cplx_pipe: directed vector table plus stall and reset sequences for the butterfly
module tb_butterfly_cplx_pipe;
    logic clk = 1'b0;
    logic i_reset, i_valid, o_ready, i_inverse, i_scale, o_valid, i_ready, o_sat;
    logic signed [15:0] xa_re, xa_im, xb_re, xb_im, w_re, w_im;
    logic signed [15:0] ya_re, ya_im, yb_re, yb_im;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic signed [15:0] xar, xai, xbr, xbi, wr, wi;
        logic inv, sc;
        logic signed [15:0] yar, yai, ybr, ybi;
        logic s;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    butterfly_cplx_pipe dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_xa_re   (xa_re),
        .i_xa_im   (xa_im),
        .i_xb_re   (xb_re),
        .i_xb_im   (xb_im),
        .i_w_re    (w_re),
        .i_w_im    (w_im),
        .i_inverse (i_inverse),
        .i_scale   (i_scale),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_ya_re   (ya_re),
        .o_ya_im   (ya_im),
        .o_yb_re   (yb_re),
        .o_yb_im   (yb_im),
        .o_sat     (o_sat)
    );

    function automatic vec_t mk(input int xar, xai, xbr, xbi, wr, wi, inv, sc, yar, yai, ybr, ybi, s);
        vec_t v;
        v.xar = 16'(xar); v.xai = 16'(xai); v.xbr = 16'(xbr); v.xbi = 16'(xbi);
        v.wr  = 16'(wr);  v.wi  = 16'(wi);  v.inv = 1'(inv);  v.sc  = 1'(sc);
        v.yar = 16'(yar); v.yai = 16'(yai); v.ybr = 16'(ybr); v.ybi = 16'(ybi);
        v.s   = 1'(s);
        return v;
    endfunction

    // xb=(10,0), w~1.0 gives t=(10,0) so ya and yb differ and carry the sample index
    function automatic vec_t seq_vec(input int k);
        return mk(100 * k, k, 10, 0, 32767, 0, 0, 0, 100 * k + 10, k, 100 * k - 10, k, 0);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic vld);
        xa_re = v.xar; xa_im = v.xai; xb_re = v.xbr; xb_im = v.xbi;
        w_re = v.wr; w_im = v.wi; i_inverse = v.inv; i_scale = v.sc;
        i_valid = vld;
    endtask

    task automatic check_y(input string nm, input vec_t v);
        n_vec++;
        if ({ya_re, ya_im, yb_re, yb_im, o_sat} !== {v.yar, v.yai, v.ybr, v.ybi, v.s}) begin
            n_err++;
            $display("FAIL %s: got ya=(%0d,%0d) yb=(%0d,%0d) sat=%0b, want ya=(%0d,%0d) yb=(%0d,%0d) sat=%0b",
                     nm, ya_re, ya_im, yb_re, yb_im, o_sat, v.yar, v.yai, v.ybr, v.ybi, v.s);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got;
        vec_t zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = mk(1000, 0, 500, 0, 32767, 0, 0, 0, 1500, 0, 500, 0, 0);
        vecs[1]  = mk(0, 0, 100, 0, 0, 32767, 0, 0, 0, 100, 0, -100, 0);
        vecs[2]  = mk(0, 0, 100, 0, 0, 32767, 1, 0, 0, -100, 0, 100, 0);
        vecs[3]  = mk(32767, 0, 32767, 0, 32767, 0, 0, 0, 32767, 0, 1, 0, 1);
        vecs[4]  = mk(32767, 0, 32767, 0, 32767, 0, 0, 1, 32767, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1000, 0, -32768, 0, 0, 0, -1000, 0, 1000, 0, 0);
        vecs[6]  = mk(-32768, -32768, 32767, 32767, 32767, 0, 0, 0, -2, -2, -32768, -32768, 1);
        vecs[7]  = mk(100, -50, 200, 300, 16384, 16384, 0, 0, 50, 200, 150, -300, 0);
        vecs[8]  = mk(100, -50, 200, 300, 16384, 16384, 1, 0, 350, 0, -150, -100, 0);
        vecs[9]  = mk(100, -50, 200, 300, 16384, 16384, 1, 1, 175, 0, -75, -50, 0);
        vecs[10] = mk(-1, 1, 0, 0, 32767, 0, 0, 1, 0, 1, 0, 1, 0);
        vecs[11] = mk(0, 0, 1000, 0, -32768, -32768, 1, 0, -1000, 1000, 1000, -1000, 0);

        i_reset = 1'b1;
        i_ready = 1'b1;
        drive(zero, 1'b0);
        step; step; step;
        i_reset = 1'b0;
        check_bit("reset_valid", o_valid, 1'b0);
        check_bit("reset_ready", o_ready, 1'b1);
        check_y("reset_data", zero);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i], 1'b1);
            step;
            i_valid = 1'b0;
            step;
            check_bit($sformatf("vec%0d_early", i), o_valid, 1'b0);
            step;
            check_bit($sformatf("vec%0d_latency", i), o_valid, 1'b1);
            check_y($sformatf("vec%0d", i), vecs[i]);
            step;
        end

        sent = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            i_ready = !(c >= 4 && c <= 6);
            if (sent < 8) drive(seq_vec(sent + 1), 1'b1);
            else i_valid = 1'b0;
            #1;
            if (o_valid && !i_ready) begin
                check_bit($sformatf("stall_ready_c%0d", c), o_ready, 1'b0);
                check_y($sformatf("stall_hold_c%0d", c), seq_vec(got + 1));
            end
            if (o_valid && i_ready) begin
                check_y($sformatf("stream_out%0d", got), seq_vec(got + 1));
                got++;
            end
            if (i_valid && o_ready) sent++;
            step;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_vec++;
        if (got != 8) begin
            n_err++;
            $display("FAIL stream_count: got %0d outputs, want 8", got);
        end
        check_bit("stream_no_extra", o_valid, 1'b0);

        for (int k = 0; k < 3; k++) begin
            drive(seq_vec(11 + k), 1'b1);
            step;
        end
        check_bit("pre_reset_valid", o_valid, 1'b1);
        check_y("pre_reset_data", seq_vec(11));
        drive(seq_vec(15), 1'b1);
        i_reset = 1'b1;
        step;
        i_reset = 1'b0;
        check_bit("flush_valid", o_valid, 1'b0);
        check_y("flush_data", zero);
        drive(seq_vec(20), 1'b1);
        step;
        i_valid = 1'b0;
        check_bit("flush_drop1", o_valid, 1'b0);
        step;
        check_bit("flush_drop2", o_valid, 1'b0);
        step;
        check_bit("post_reset_valid", o_valid, 1'b1);
        check_y("post_reset_data", seq_vec(20));
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
